// File: rtl/coffee_dispense_sequencer_pkg.sv
// Shared types for the coffee dispense sequencer: beverage codes, station order
// and the sequencer FSM state encoding.
package coffee_pkg;

   localparam int NUM_INGREDIENTS = 5;

   typedef enum logic [2:0] {
      EXPRESO   = 3'd1,
      WITH_MILK = 3'd2,
      CAPUCCINO = 3'd3,
      MOCACCINO = 3'd4
   } coffee_t;

   typedef enum logic [2:0] {
      WATER     = 3'd0,
      COFFEE    = 3'd1,
      MILK      = 3'd2,
      CHOCOLATE = 3'd3,
      SUGAR     = 3'd4
   } ingredient_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DISPENSE,
      S_NEXT,
      S_FINISH
   } seq_state_t;

   function automatic logic is_valid_coffee(input logic [2:0] sel);
      return (sel >= 3'(EXPRESO)) && (sel <= 3'(MOCACCINO));
   endfunction

endpackage

// File: rtl/coffee_dispense_sequencer_if.sv
// Front-panel / lookup / valve bundle of the sequencer. The slave modport is the
// sequencer itself; the master modport is whatever drives selection and the lookup.
interface coffee_dispense_sequencer_if;
   import coffee_pkg::*;

   logic                       start;
   logic                       cancel;
   logic [2:0]                 coffee_type;
   logic [1:0]                 ingredient_time;
   logic [2:0]                 lookup_type;
   logic [2:0]                 lookup_state;
   logic [NUM_INGREDIENTS-1:0] valve;
   logic                       busy;
   logic                       done;
   logic                       error;

   modport master (
      output start, cancel, coffee_type, ingredient_time,
      input  lookup_type, lookup_state, valve, busy, done, error
   );

   modport slave (
      input  start, cancel, coffee_type, ingredient_time,
      output lookup_type, lookup_state, valve, busy, done, error
   );

endinterface

// File: rtl/coffee_dispense_sequencer_unit_tick_gen.sv
// Time-unit prescaler: counts 0..CLKS_PER_UNIT-1 while enabled and flags the
// last count of each unit with a one-cycle tick.
module unit_tick_gen #(
   parameter int CLKS_PER_UNIT = 50_000_000,
   parameter int CNT_W         = $clog2(CLKS_PER_UNIT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_UNIT - 1);

   logic [CNT_W-1:0] cnt_reg;

   // Tick marks the cycle the counter wraps, so a unit spans exactly CLKS_PER_UNIT enabled cycles.
   assign tick = en && !clr && (cnt_reg == LAST_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (en) begin
         cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/coffee_dispense_sequencer.sv
// Beverage cycle controller: walks the five stations in order, asks the lookup
// for each station's time and holds that station's valve open for it.
module coffee_dispense_sequencer
   import coffee_pkg::*;
#(
   parameter int CLKS_PER_UNIT = 50_000_000,
   parameter int CNT_W         = $clog2(CLKS_PER_UNIT)
) (
   input logic                        clk,
   input logic                        rst_n,
   coffee_dispense_sequencer_if.slave bus
);

   seq_state_t                 state_reg;
   logic [2:0]                 lookup_type_reg;
   logic [2:0]                 lookup_state_reg;
   logic [NUM_INGREDIENTS-1:0] valve_reg;
   logic [1:0]                 unit_cnt_reg;
   logic                       done_reg;
   logic                       error_reg;
   logic                       tick;

   unit_tick_gen #(
      .CLKS_PER_UNIT (CLKS_PER_UNIT),
      .CNT_W         (CNT_W)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_reg == S_LOAD),
      .en    (state_reg == S_DISPENSE),
      .tick  (tick)
   );

   assign bus.lookup_type  = lookup_type_reg;
   assign bus.lookup_state = lookup_state_reg;
   assign bus.valve        = valve_reg;
   assign bus.busy         = (state_reg != S_IDLE);
   assign bus.done         = done_reg;
   assign bus.error        = error_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= S_IDLE;
         lookup_type_reg  <= '0;
         lookup_state_reg <= '0;
         valve_reg        <= '0;
         unit_cnt_reg     <= '0;
         done_reg         <= 1'b0;
         error_reg        <= 1'b0;
      end else begin
         done_reg  <= 1'b0;
         error_reg <= 1'b0;
         // Abort outranks everything once a beverage is under way, even the last wrap and FINISH.
         if (state_reg != S_IDLE && bus.cancel) begin
            state_reg        <= S_IDLE;
            valve_reg        <= '0;
            lookup_state_reg <= '0;
         end else begin
            unique case (state_reg)
               S_IDLE: begin
                  if (bus.start) begin
                     if (is_valid_coffee(bus.coffee_type)) begin
                        lookup_type_reg  <= bus.coffee_type;
                        lookup_state_reg <= '0;
                        state_reg        <= S_LOAD;
                     end else begin
                        error_reg <= 1'b1;
                     end
                  end
               end
               S_LOAD: begin
                  unit_cnt_reg <= bus.ingredient_time;
                  if (bus.ingredient_time == 2'd0) begin
                     state_reg <= S_NEXT;
                  end else begin
                     valve_reg <= {{(NUM_INGREDIENTS-1){1'b0}}, 1'b1} << lookup_state_reg;
                     state_reg <= S_DISPENSE;
                  end
               end
               S_DISPENSE: begin
                  if (tick) begin
                     unit_cnt_reg <= unit_cnt_reg - 2'd1;
                     if (unit_cnt_reg == 2'd1) begin
                        valve_reg <= '0;
                        state_reg <= S_NEXT;
                     end
                  end
               end
               S_NEXT: begin
                  if (lookup_state_reg == 3'(SUGAR)) begin
                     state_reg <= S_FINISH;
                  end else begin
                     lookup_state_reg <= lookup_state_reg + 3'd1;
                     state_reg        <= S_LOAD;
                  end
               end
               S_FINISH: begin
                  done_reg         <= 1'b1;
                  lookup_state_reg <= '0;
                  state_reg        <= S_IDLE;
               end
               default: state_reg <= S_IDLE;
            endcase
         end
      end
   end

endmodule
